// File: rtl/pwm_decoder_pkg.sv
// Shared types and default constants for the PWM frame decoder.
package pwm_decoder_pkg;

    localparam int CLK_HZ      = 10_000_000;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1023;
    localparam int DEF_NOTE_W  = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } dec_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM line, plus a delayed copy for edge detection.
module pwm_edge_sync (
    input  logic clk,
    input  logic RST,
    input  logic pwm,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (RST) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= pwm;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/pwm_decoder.sv
// Measures high time and period of each PWM frame and strobes one result per frame.
// Optional note detection is enabled with the PWM_DECODER_NOTE_DETECT_EN macro.
module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int NOTE_W  = DEF_NOTE_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              en,
    input  logic              pwm_i,
    output logic [CNT_W-1:0]  duty_o,
    output logic [CNT_W-1:0]  period_o,
    output logic              valid_o,
    output logic              idle_o,
    output logic              level_o,
    output logic [NOTE_W-1:0] note_period_o,
    output logic              note_valid_o
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic             level;
    logic             rise;
    logic             fall;
    dec_state_e       state;
    dec_state_e       nxt_state;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_nxt;
    logic [CNT_W-1:0] per_nxt;
    logic             close_frame;
    logic             timed_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    pwm_edge_sync u_edge_sync (
        .clk   (clk),
        .RST   (RST),
        .pwm   (pwm_i),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign timed_out = (per_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Timeout beats a coinciding rise, so the longest accepted period is TIMEOUT-1.
    always_comb begin
        nxt_state = state;
        if (!en) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) nxt_state = HIGH;
                HIGH:    if (timed_out) nxt_state = IDLE; else if (fall) nxt_state = LOW;
                LOW:     if (timed_out) nxt_state = IDLE; else if (rise) nxt_state = HIGH;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_comb begin
        hi_nxt      = hi_cnt;
        per_nxt     = per_cnt;
        close_frame = 1'b0;
        if (nxt_state == IDLE) begin
            hi_nxt  = '0;
            per_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    hi_nxt  = CNT_W'(1);
                    per_nxt = CNT_W'(1);
                end
                HIGH: begin
                    per_nxt = sat_inc(per_cnt);
                    if (!fall) hi_nxt = sat_inc(hi_cnt);
                end
                LOW: begin
                    if (rise) begin
                        close_frame = 1'b1;
                        hi_nxt      = CNT_W'(1);
                        per_nxt     = CNT_W'(1);
                    end else begin
                        per_nxt = sat_inc(per_cnt);
                    end
                end
                default: begin
                    hi_nxt  = '0;
                    per_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            hi_cnt   <= '0;
            per_cnt  <= '0;
            duty_o   <= '0;
            period_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            hi_cnt  <= hi_nxt;
            per_cnt <= per_nxt;
            valid_o <= close_frame;
            if (close_frame) begin
                duty_o   <= hi_cnt;
                period_o <= per_cnt;
            end
        end
    end

    assign idle_o  = (state == IDLE);
    assign level_o = level;

`ifdef PWM_DECODER_NOTE_DETECT_EN
    localparam logic [NOTE_W-1:0] NOTE_MAX = '1;

    logic [NOTE_W-1:0] note_cnt;
    logic              armed;
    logic              prev_above;
    logic              above;
    logic              up_cross;

    assign above    = ({hi_cnt, 1'b0} >= {1'b0, per_cnt});
    assign up_cross = close_frame && above && !prev_above;

    // The first up-crossing after idle only arms the counter; later ones report it.
    always_ff @(posedge clk) begin
        if (RST) begin
            note_cnt      <= '0;
            armed         <= 1'b0;
            prev_above    <= 1'b0;
            note_period_o <= '0;
            note_valid_o  <= 1'b0;
        end else begin
            note_valid_o <= up_cross && armed;
            if (nxt_state == IDLE) begin
                note_cnt   <= '0;
                armed      <= 1'b0;
                prev_above <= 1'b0;
            end else begin
                if (up_cross) begin
                    note_cnt <= NOTE_W'(1);
                    armed    <= 1'b1;
                    if (armed) note_period_o <= note_cnt;
                end else if (note_cnt != NOTE_MAX) begin
                    note_cnt <= note_cnt + NOTE_W'(1);
                end
                if (close_frame) prev_above <= above;
            end
        end
    end
`else
    assign note_period_o = '0;
    assign note_valid_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_decoder.sv
// Randomized self-checking bench for pwm_decoder; the reference model works from rise/fall times of the driven stream.
module tb_pwm_decoder;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1023;
    localparam int NOTE_W  = 20;

    logic              tb_clk = 1'b0;
    logic              rst;
    logic              en;
    logic              pwm_i;
    logic [CNT_W-1:0]  duty_o;
    logic [CNT_W-1:0]  period_o;
    logic              valid_o;
    logic              idle_o;
    logic              level_o;
    logic [NOTE_W-1:0] note_period_o;
    logic              note_valid_o;

    pwm_decoder #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .NOTE_W  (NOTE_W)
    ) dut (
        .clk           (tb_clk),
        .RST           (rst),
        .en            (en),
        .pwm_i         (pwm_i),
        .duty_o        (duty_o),
        .period_o      (period_o),
        .valid_o       (valid_o),
        .idle_o        (idle_o),
        .level_o       (level_o),
        .note_period_o (note_period_o),
        .note_valid_o  (note_valid_o)
    );

    always #50 tb_clk = ~tb_clk;

    typedef struct {
        int duty;
        int period;
        int at;
        bit note_valid;
        int note_period;
    } frame_t;

    frame_t exp_q[$];
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     cyc          = 0;

    bit in_run        = 1'b0;
    bit model_en      = 1'b1;
    bit armed         = 1'b0;
    bit prev_above    = 1'b0;
    int rise_cyc      = 0;
    int fall_cyc      = 0;
    int last_cross_at = 0;
    int last_duty     = 0;
    int last_period   = 0;
    logic valid_prev  = 1'b0;

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // A rise closes the frame that began at the previous rise, if one was being tracked and it did not time out.
    task automatic modelRise();
        frame_t f;
        int     p;
        int     d;
        p = cyc - rise_cyc;
        d = fall_cyc - rise_cyc;
        if (model_en && in_run && p < TIMEOUT) begin
            f.duty        = d;
            f.period      = p;
            f.at          = cyc + 3;
            f.note_valid  = 1'b0;
            f.note_period = 0;
`ifdef PWM_DECODER_NOTE_DETECT_EN
            if (2 * d >= p && !prev_above) begin
                if (armed) begin
                    f.note_valid  = 1'b1;
                    f.note_period = f.at - last_cross_at;
                end
                armed         = 1'b1;
                last_cross_at = f.at;
            end
            prev_above = (2 * d >= p);
`endif
            exp_q.push_back(f);
            last_duty   = d;
            last_period = p;
        end else begin
            armed      = 1'b0;
            prev_above = 1'b0;
        end
        in_run   = model_en;
        rise_cyc = cyc;
    endtask

    task automatic applyStimulus(input logic lvl, input int n);
        if (lvl && !pwm_i) modelRise();
        else if (!lvl && pwm_i) fall_cyc = cyc;
        pwm_i = lvl;
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic sendFrame(input int h, input int l);
        applyStimulus(1'b1, h);
        applyStimulus(1'b0, l);
    endtask

    task automatic setEnable(input logic v);
        en       = v;
        model_en = v;
        if (!v) begin
            in_run     = 1'b0;
            armed      = 1'b0;
            prev_above = 1'b0;
        end
    endtask

    // Releasing reset with the line high looks like a fresh rise to the synchronizer.
    task automatic resetDut(input int n, input bit toggle, input logic release_level);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (toggle) pwm_i = ~pwm_i;
            @(negedge tb_clk);
        end
        checkOutput("rst_duty", 64'(duty_o), 64'(0));
        checkOutput("rst_period", 64'(period_o), 64'(0));
        checkOutput("rst_valid", 64'(valid_o), 64'(0));
        checkOutput("rst_idle", 64'(idle_o), 64'(1));
        checkOutput("rst_level", 64'(level_o), 64'(0));
        checkOutput("rst_note_period", 64'(note_period_o), 64'(0));
        checkOutput("rst_note_valid", 64'(note_valid_o), 64'(0));
        pwm_i       = release_level;
        rst         = 1'b0;
        in_run      = release_level && model_en;
        rise_cyc    = cyc;
        fall_cyc    = cyc;
        armed       = 1'b0;
        prev_above  = 1'b0;
        last_duty   = 0;
        last_period = 0;
    endtask

    always @(negedge tb_clk) begin
        frame_t f;
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            checkOutput("valid_missing", 64'(cyc), 64'(exp_q[0].at));
            void'(exp_q.pop_front());
        end
        if (valid_o) begin
            checkOutput("strobe_width", 64'(valid_prev), 64'(0));
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", 64'(valid_o), 64'(0));
            end else begin
                f = exp_q.pop_front();
                checkOutput("valid_cycle", 64'(cyc), 64'(f.at));
                checkOutput("duty", 64'(duty_o), 64'(f.duty));
                checkOutput("period", 64'(period_o), 64'(f.period));
                checkOutput("note_valid", 64'(note_valid_o), 64'(f.note_valid));
                if (f.note_valid) checkOutput("note_period", 64'(note_period_o), 64'(f.note_period));
            end
        end else if (note_valid_o) begin
            checkOutput("note_stray", 64'(note_valid_o), 64'(0));
        end
        valid_prev = valid_o;
    end

    initial begin
        int h;
        int l;
        int sel;
        rst   = 1'b1;
        en    = 1'b1;
        pwm_i = 1'b0;
        @(negedge tb_clk);

        resetDut(2, 1'b1, 1'b0);
        applyStimulus(1'b0, 5);

        repeat (4) sendFrame(64, 192);
        checkOutput("idle_running", 64'(idle_o), 64'(0));

        applyStimulus(1'b1, TIMEOUT + 2);
        checkOutput("idle_before_timeout", 64'(idle_o), 64'(0));
        applyStimulus(1'b1, 1);
        checkOutput("idle_after_timeout", 64'(idle_o), 64'(1));
        checkOutput("level_stuck_high", 64'(level_o), 64'(1));
        checkOutput("duty_held", 64'(duty_o), 64'(last_duty));
        checkOutput("period_held", 64'(period_o), 64'(last_period));
        applyStimulus(1'b0, 50);
        checkOutput("idle_low", 64'(idle_o), 64'(1));
        checkOutput("level_stuck_low", 64'(level_o), 64'(0));

        repeat (2) sendFrame(64, 192);
        applyStimulus(1'b1, 20);
        setEnable(1'b0);
        applyStimulus(1'b1, 10);
        checkOutput("idle_en_low", 64'(idle_o), 64'(1));
        setEnable(1'b1);
        applyStimulus(1'b1, 34);
        applyStimulus(1'b0, 192);
        repeat (3) sendFrame(64, 192);

        applyStimulus(1'b1, 30);
        resetDut(1, 1'b0, 1'b1);
        applyStimulus(1'b1, 34);
        applyStimulus(1'b0, 192);
        repeat (3) sendFrame(64, 192);
        applyStimulus(1'b1, 2);
        resetDut(1, 1'b0, 1'b1);
        applyStimulus(1'b1, 62);
        applyStimulus(1'b0, 192);
        repeat (2) sendFrame(64, 192);

        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 15));
            h   = int'($urandom_range(1, 300));
            l   = int'($urandom_range(1, 300));
            case (sel)
                0: h = 1;
                1: l = 1;
                2: l = TIMEOUT + 1 + int'($urandom_range(0, 60));
                3: begin h = int'($urandom_range(1, 100)); l = TIMEOUT - 1 - h; end
                4: h = TIMEOUT + int'($urandom_range(1, 40));
                5: begin h = 1; l = 1; end
                default: ;
            endcase
            sendFrame(h, l);
        end

`ifdef PWM_DECODER_NOTE_DETECT_EN
        for (int k = 0; k < 24; k++) begin
            if (((k / 3) % 2) == 1) sendFrame(90, 10);
            else sendFrame(10, 90);
        end
`endif

        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 10);
        checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
